// File: rtl/bcp_sweep_sequencer_if.sv
// Bundle between the BCP sweep sequencer and host / memory / check engines.
// master: sequencer side (drives requests); slave: environment side.
interface bcp_sweep_sequencer_if #(
    parameter int ADDR_W    = 3,
    parameter int NUM_CHECK = 8,
    parameter int CNT_W     = 8
);
    logic                 system_initial_signal;
    logic                 initial_finish;
    logic                 bcp_request;
    logic                 mem_finish;
    logic [NUM_CHECK-1:0] bcp_finish;
    logic [NUM_CHECK-1:0] bcp_conflict;
    logic [NUM_CHECK-1:0] bcp_implied;
    logic                 ca_finish;
    logic                 ca_unsat;
    logic                 select_var_finish;
    logic                 all_assigned;

    logic                 initial_request;
    logic                 mem_request;
    logic                 mem_read;
    logic                 mem_write;
    logic [ADDR_W-1:0]    mem_address;
    logic                 check_start;
    logic                 conflict_analysis_request;
    logic                 select_var_request;
    logic                 done;
    logic                 result_sat;
    logic [CNT_W-1:0]     pass_count;

    modport master (
        input  system_initial_signal, initial_finish, bcp_request,
        input  mem_finish, bcp_finish, bcp_conflict, bcp_implied,
        input  ca_finish, ca_unsat, select_var_finish, all_assigned,
        output initial_request, mem_request, mem_read, mem_write,
        output mem_address, check_start, conflict_analysis_request,
        output select_var_request, done, result_sat, pass_count
    );

    modport slave (
        output system_initial_signal, initial_finish, bcp_request,
        output mem_finish, bcp_finish, bcp_conflict, bcp_implied,
        output ca_finish, ca_unsat, select_var_finish, all_assigned,
        input  initial_request, mem_request, mem_read, mem_write,
        input  mem_address, check_start, conflict_analysis_request,
        input  select_var_request, done, result_sat, pass_count
    );
endinterface

// File: rtl/bcp_sweep_sequencer.sv
// Autonomous BCP sweep sequencer: sweeps clause blocks, iterates to fixpoint,
// then conflict analysis or decision, until SAT/UNSAT. Ports: clock, reset, bus.
module bcp_sweep_sequencer #(
    parameter int ADDR_W     = 3,
    parameter int NUM_BLOCKS = 8,
    parameter int NUM_CHECK  = 8,
    parameter int CNT_W      = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    bcp_sweep_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_MEM, S_CHECK, S_EVAL, S_CA, S_SELECT, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_BLK = ADDR_W'(NUM_BLOCKS - 1);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    blk_q, blk_d;
    logic [NUM_CHECK-1:0] mask_q, mask_d;
    logic                 conf_q, conf_d;
    logic                 impl_q, impl_d;
    logic                 first_q, first_d;
    logic                 sat_q, sat_d;
    logic [CNT_W-1:0]     pass_q, pass_d;

    logic [NUM_CHECK-1:0] mask_all;
    logic                 conf_all;
    logic                 impl_all;
    logic [CNT_W-1:0]     pass_inc;

    // Include this cycle's arrivals so completion is seen without a bubble.
    assign mask_all = mask_q | bus.bcp_finish;
    assign conf_all = conf_q | (|(bus.bcp_conflict & bus.bcp_finish));
    assign impl_all = impl_q | (|(bus.bcp_implied & bus.bcp_finish));
    assign pass_inc = (&pass_q) ? pass_q : pass_q + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            blk_q   <= '0;
            mask_q  <= '0;
            conf_q  <= 1'b0;
            impl_q  <= 1'b0;
            first_q <= 1'b0;
            sat_q   <= 1'b0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            mask_q  <= mask_d;
            conf_q  <= conf_d;
            impl_q  <= impl_d;
            first_q <= first_d;
            sat_q   <= sat_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        mask_d  = mask_q;
        conf_d  = conf_q;
        impl_d  = impl_q;
        first_d = 1'b0;
        sat_d   = sat_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.bcp_request) begin
                    blk_d   = '0;
                    pass_d  = '0;
                    sat_d   = 1'b0;
                    conf_d  = 1'b0;
                    impl_d  = 1'b0;
                    state_d = S_MEM;
                end else if (bus.system_initial_signal) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (bus.initial_finish) state_d = S_IDLE;
            end
            S_MEM: begin
                mask_d = '0;
                if (bus.mem_finish) begin
                    first_d = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                mask_d = mask_all;
                conf_d = conf_all;
                impl_d = impl_all;
                if (&mask_all) begin
                    if (conf_all || blk_q == LAST_BLK) begin
                        state_d = S_EVAL;
                    end else begin
                        blk_d   = blk_q + 1'b1;
                        state_d = S_MEM;
                    end
                end
            end
            S_EVAL: begin
                if (conf_q) begin
                    state_d = S_CA;
                end else if (impl_q) begin
                    pass_d  = pass_inc;
                    blk_d   = '0;
                    conf_d  = 1'b0;
                    impl_d  = 1'b0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_SELECT;
                end
            end
            S_CA: begin
                if (bus.ca_finish) begin
                    if (bus.ca_unsat) begin
                        sat_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        pass_d  = pass_inc;
                        blk_d   = '0;
                        conf_d  = 1'b0;
                        impl_d  = 1'b0;
                        state_d = S_MEM;
                    end
                end
            end
            S_SELECT: begin
                if (bus.select_var_finish) begin
                    if (bus.all_assigned) begin
                        sat_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        pass_d  = pass_inc;
                        blk_d   = '0;
                        conf_d  = 1'b0;
                        impl_d  = 1'b0;
                        state_d = S_MEM;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.initial_request           = (state_q == S_INIT);
    assign bus.mem_request               = (state_q == S_MEM);
    assign bus.mem_read                  = (state_q == S_MEM);
    assign bus.mem_write                 = 1'b0;
    assign bus.mem_address               = blk_q;
    assign bus.check_start               = (state_q == S_CHECK) && first_q;
    assign bus.conflict_analysis_request = (state_q == S_CA);
    assign bus.select_var_request        = (state_q == S_SELECT);
    assign bus.done                      = (state_q == S_DONE);
    assign bus.result_sat                = sat_q;
    assign bus.pass_count                = pass_q;

endmodule
